// File: rtl/mac_accumulator_if.sv
// ============================================================================
//  Module      : mac_accumulator_if
//  Description : Streaming bus for the MAC stage. Carries the window-abort
//                strobe, the pixel/weight input handshake and the saturated
//                window-sum output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_accumulator_if #(
  parameter int DW    = 8,
  parameter int OUT_W = 16
) ();

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    pixel;
  logic signed [DW-1:0]    weight;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  // Producer/consumer side of the stage (upstream source + downstream sink)
  modport master (
    output clear, in_valid, pixel, weight, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The MAC stage itself
  modport slave (
    input  clear, in_valid, pixel, weight, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ============================================================================
//  Module      : mac_accumulator
//  Description : Streaming signed multiply-accumulate. Sums KLEN pixel*weight
//                products per window and emits the sum saturated to OUT_W
//                bits through a one-entry output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accumulator #(
  parameter int DW    = 8,
  parameter int KLEN  = 9,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mac_accumulator_if.slave bus
);

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] C_PENULT_CNT = CNT_W'(KLEN - 2);

  // ACCUM while cnt < KLEN-1, LAST while the next accept closes the window
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  logic signed [2*DW-1:0]  w_product;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic [ACC_W-OUT_W:0]    w_sum_hi;
  logic                    w_ovf;
  logic signed [OUT_W-1:0] w_sat_data;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_load;

  // Full-precision product, sign-extended into the accumulator domain
  assign w_product  = bus.pixel * bus.weight;
  assign w_prod_ext = {{(ACC_W - 2*DW){w_product[2*DW-1]}}, w_product};
  assign w_sum      = r_acc + w_prod_ext;

  // The sum fits in OUT_W bits only when all bits from OUT_W-1 up are equal
  assign w_sum_hi   = w_sum[ACC_W-1:OUT_W-1];
  assign w_ovf      = !((&w_sum_hi) || !(|w_sum_hi));
  assign w_sat_data = !w_ovf        ? w_sum[OUT_W-1:0] :
                      w_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                       {1'b0, {(OUT_W-1){1'b1}}};

  // Only the closing beat has to wait for the output register to drain
  assign w_in_ready = !((r_state == LAST) && r_out_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.clear;
  assign w_load     = w_accept && (r_state == LAST);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  // Window sequencing, accumulation and the one-entry result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (bus.clear) begin
        r_state <= ACCUM;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (w_accept) begin
        if (r_state == LAST) begin
          // Window closed; beat 0 of the next window reloads acc directly
          r_state <= ACCUM;
          r_cnt   <= '0;
        end else begin
          r_acc   <= (r_cnt == '0) ? w_prod_ext : w_sum;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == C_PENULT_CNT) ? LAST : ACCUM;
        end
      end

      // A reload in the same cycle as a hand-off keeps out_valid high
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sat_data;
        r_out_sat   <= w_ovf;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
//  Module      : tb_mac_accumulator
//  Description : Directed scoreboard bench for mac_accumulator (DW=8, KLEN=9,
//                OUT_W=16). Drivers push hand-computed window sums; a monitor
//                pops them on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accumulator;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   stalls;

  int   sb_d[$];
  int   sb_s[$];
  int   hs_cyc[$];

  logic signed [7:0] bp[9];
  logic signed [7:0] bw[9];

  mac_accumulator_if #(.DW(8), .OUT_W(16)) bus ();

  mac_accumulator #(
    .DW   (8),
    .KLEN (9),
    .ACC_W(24),
    .OUT_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int s);
    sb_d.push_back(d);
    sb_s.push_back(s);
  endtask

  // Present one beat and return at posedge+1 after it was accepted
  task automatic send_beat(input logic signed [7:0] p, input logic signed [7:0] w);
    int  n;
    bit  done;
    bus.pixel    = p;
    bus.weight   = w;
    bus.in_valid = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_const(input logic signed [7:0] p, input logic signed [7:0] w,
                            input int ed, input int es);
    push(ed, es);
    for (int i = 0; i < 9; i++) send_beat(p, w);
  endtask

  task automatic send_arr(input int ed, input int es);
    push(ed, es);
    for (int i = 0; i < 9; i++) send_beat(bp[i], bw[i]);
  endtask

  // Monitor: pop and compare on every handshake; a stalled result must hold
  initial begin : monitor
    logic signed [15:0] held;
    bit                 stalled;
    int                 ed;
    int                 es;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (stalled) check("hold_stable", int'(bus.out_data), int'(held));
        if (bus.out_ready) begin
          stalled = 1'b0;
          hs_cyc.push_back(cyc);
          if (sb_d.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %0d expected no output", bus.out_data);
          end else begin
            ed = sb_d.pop_front();
            es = sb_s.pop_front();
            check("out_data", int'(bus.out_data), ed);
            check("out_sat", int'(bus.out_sat), es);
          end
        end else begin
          stalled = 1'b1;
          held    = bus.out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : main
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    stalls = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pixel     = '0;
    bus.weight    = '0;
    bus.out_ready = 1'b1;
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);

    // 1: 10*3 x9 = 270, latency one cycle after the last accept
    for (int i = 0; i < 8; i++) send_beat(8'sd10, 8'sd3);
    check("t1_no_early_valid", int'(bus.out_valid), 0);
    push(270, 0);
    send_beat(8'sd10, 8'sd3);
    check("t1_latency_valid", int'(bus.out_valid), 1);
    idle(2);

    // 2: saturation both ways
    send_const(8'sd127, 8'sd127, 32767, 1);
    send_const(-8'sd128, 8'sd127, -32768, 1);
    idle(2);

    // Boundaries: exactly +32768 clips, +32767 and -32768 pass untouched
    for (int i = 0; i < 9; i++) begin bp[i] = '0; bw[i] = '0; end
    bp[0] = -8'sd128; bw[0] = -8'sd128;
    bp[5] = -8'sd128; bw[5] = -8'sd128;
    send_arr(32767, 1);
    bp[5] = 8'sd127; bw[5] = 8'sd127;
    bp[8] = 8'sd127; bw[8] = 8'sd2;
    send_arr(32767, 0);
    bp[0] = -8'sd128; bw[0] = 8'sd127;
    bp[5] = -8'sd128; bw[5] = 8'sd127;
    bp[8] = -8'sd128; bw[8] = 8'sd2;
    send_arr(-32768, 0);
    idle(2);

    // 3: A stalls in the output register while B streams in
    bus.out_ready = 1'b0;
    push(90, 0);
    for (int i = 0; i < 9; i++) send_beat(8'(i + 1), 8'sd2);
    stalls = 0;
    for (int i = 0; i < 8; i++) send_beat(-8'sd5, 8'sd7);
    check("t3_b_beats_accepted", stalls, 0);
    bus.pixel  = -8'sd5;
    bus.weight = 8'sd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_last_beat_blocked", int'(bus.in_ready), 0);
      check("t3_a_valid_held", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    push(-315, 0);
    send_beat(-8'sd5, 8'sd7);
    idle(3);

    // 4: back-to-back windows at full rate
    hs_cyc.delete();
    stalls = 0;
    send_const(8'sd100, -8'sd20, -18000, 0);
    for (int i = 0; i < 9; i++) begin bp[i] = 8'(i); bw[i] = 8'(i); end
    send_arr(204, 0);
    send_const(8'sd50, 8'sd80, 32767, 1);
    idle(3);
    check("t4_never_stalled", stalls, 0);
    check("t4_outputs", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("t4_gap1", hs_cyc[1] - hs_cyc[0], 9);
      check("t4_gap2", hs_cyc[2] - hs_cyc[1], 9);
    end

    // 5: clear after 4 beats discards them, accept during clear is ignored
    for (int i = 0; i < 4; i++) send_beat(8'sd10, 8'sd10);
    bus.pixel  = 8'sd99;
    bus.weight = 8'sd99;
    bus.clear  = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    send_const(8'sd2, 8'sd3, 54, 0);
    idle(2);
    // clear with a pending result: result still drains
    bus.out_ready = 1'b0;
    send_const(8'sd1, 8'sd1, 9, 0);
    idle(1);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    idle(2);
    check("t5_pending_kept", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    idle(2);

    // 6: asynchronous reset mid-window with a result pending
    bus.out_ready = 1'b0;
    send_const(8'sd3, 8'sd3, 81, 0);
    for (int i = 0; i < 4; i++) send_beat(8'sd7, 8'sd7);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_valid", int'(bus.out_valid), 0);
    check("t6_async_data", int'(bus.out_data), 0);
    sb_d.delete();
    sb_s.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ready_after_rst", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    send_const(-8'sd4, 8'sd6, -216, 0);
    idle(10);

    check("scoreboard_drained", sb_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
